// File: rtl/freq_check_pkg.sv
// Shared types and default parameter values for the divided-clock frequency checker.
package freq_check_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MEASURE = 2'd1,
    ST_LOCKED  = 2'd2,
    ST_FAULT   = 2'd3
  } state_t;

  localparam int unsigned DEF_CNT_W      = 16;
  localparam int unsigned DEF_EXP_PERIOD = 4;
  localparam int unsigned DEF_TOL        = 0;
  localparam int unsigned DEF_LOCK_COUNT = 4;
  localparam int unsigned DEF_TIMEOUT    = 16;

endpackage

// File: rtl/edge_sync.sv
// Two-flop synchronizer for div_in plus a previous-value flop; flags a rising edge.
module edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic div_in,
  output logic rise
);

  logic sync0;
  logic sync1;
  logic prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync0 <= 1'b0;
      sync1 <= 1'b0;
      prev  <= 1'b0;
    end else begin
      sync0 <= div_in;
      sync1 <= sync0;
      prev  <= sync1;
    end
  end

  assign rise = sync1 & ~prev;

endmodule

// File: rtl/freq_check.sv
// Measures the period of a divided clock, locks after consecutive in-tolerance
// periods and flags a sticky fault on deviation or loss of edges.
module freq_check
  import freq_check_pkg::*;
#(
  parameter int unsigned CNT_W      = DEF_CNT_W,
  parameter int unsigned EXP_PERIOD = DEF_EXP_PERIOD,
  parameter int unsigned TOL        = DEF_TOL,
  parameter int unsigned LOCK_COUNT = DEF_LOCK_COUNT,
  parameter int unsigned TIMEOUT    = DEF_TIMEOUT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             div_in,
  input  logic             clr,
  output logic [CNT_W-1:0] period_out,
  output logic             period_valid,
  output logic             locked,
  output logic             fault
);

  localparam int unsigned GOOD_W = $clog2(LOCK_COUNT + 1);

  localparam logic [CNT_W:0]    EXP_C     = (CNT_W + 1)'(EXP_PERIOD);
  localparam logic [CNT_W:0]    TOL_C     = (CNT_W + 1)'(TOL);
  localparam logic [CNT_W-1:0]  TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam logic [GOOD_W-1:0] LOCK_C    = GOOD_W'(LOCK_COUNT);

  logic rise;

  state_t            state,    state_nxt;
  logic [CNT_W-1:0]  cnt,      cnt_nxt;
  logic [GOOD_W-1:0] good_cnt, good_nxt;
  logic [CNT_W-1:0]  pout_nxt;
  logic              pv_nxt;

  logic [CNT_W-1:0]  cnt_inc;
  logic [GOOD_W-1:0] good_inc;
  logic [CNT_W:0]    cnt_ext;
  logic [CNT_W:0]    dev;
  logic              match;
  logic              timeout;

  edge_sync u_edge_sync (
    .clk    (clk),
    .rst    (rst),
    .div_in (div_in),
    .rise   (rise)
  );

  // Deviation is taken one bit wider than the counter so it never wraps.
  always_comb begin
    cnt_ext  = {1'b0, cnt};
    dev      = (cnt_ext >= EXP_C) ? (cnt_ext - EXP_C) : (EXP_C - cnt_ext);
    match    = (dev <= TOL_C);
    cnt_inc  = (cnt == '1) ? cnt : cnt + 1'b1;
    good_inc = (good_cnt == LOCK_C) ? good_cnt : good_cnt + 1'b1;
    timeout  = (cnt >= TIMEOUT_C);
  end

  // Priority: clr over rise, rise over timeout.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt_inc;
    good_nxt  = good_cnt;
    pout_nxt  = period_out;
    pv_nxt    = 1'b0;

    if (clr) begin
      state_nxt = ST_IDLE;
      cnt_nxt   = '0;
      good_nxt  = '0;
    end else if (rise) begin
      cnt_nxt = {{(CNT_W - 1){1'b0}}, 1'b1};
      if (state != ST_IDLE) begin
        pout_nxt = cnt;
        pv_nxt   = 1'b1;
      end
      case (state)
        ST_IDLE: state_nxt = ST_MEASURE;
        ST_MEASURE: begin
          if (match) begin
            good_nxt = good_inc;
            if (good_inc == LOCK_C) begin
              state_nxt = ST_LOCKED;
            end
          end else begin
            good_nxt = '0;
          end
        end
        ST_LOCKED: begin
          if (!match) begin
            state_nxt = ST_FAULT;
          end
        end
        default: state_nxt = ST_FAULT;
      endcase
    end else if (state != ST_FAULT && timeout) begin
      state_nxt = ST_FAULT;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      cnt          <= '0;
      good_cnt     <= '0;
      period_out   <= '0;
      period_valid <= 1'b0;
      locked       <= 1'b0;
      fault        <= 1'b0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      good_cnt     <= good_nxt;
      period_out   <= pout_nxt;
      period_valid <= pv_nxt;
      locked       <= (state_nxt == ST_LOCKED);
      fault        <= (state_nxt == ST_FAULT);
    end
  end

endmodule

// File: tb/tb_freq_check.sv
// Bench for freq_check: a default instance and a TOL=1 instance share stimulus
// and are compared every cycle against a timestamp-based reference model.
module tb_freq_check;

  logic        clk = 1'b0;
  logic        rst;
  logic        div_in;
  logic        clr;
  logic [15:0] pout [2];
  logic        pv   [2];
  logic        lk   [2];
  logic        ft   [2];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  freq_check u0 (
    .clk (clk), .rst (rst), .div_in (div_in), .clr (clr),
    .period_out (pout[0]), .period_valid (pv[0]), .locked (lk[0]), .fault (ft[0])
  );

  freq_check #(.TOL(1)) u1 (
    .clk (clk), .rst (rst), .div_in (div_in), .clr (clr),
    .period_out (pout[1]), .period_valid (pv[1]), .locked (lk[1]), .fault (ft[1])
  );

  // Reference model: the period is the distance between edge timestamps.
  localparam int M_IDLE = 0, M_MEAS = 1, M_LOCK = 2, M_FLT = 3;
  int tolv [2] = '{0, 1};
  int m_state [2];
  int m_good  [2];
  int m_tref  [2];
  int m_pout  [2];
  bit m_pv    [2];
  bit hist [$];
  int n_edge;

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    hist = '{0, 0, 0, 0};
    n_edge = 0;
    for (int i = 0; i < 2; i++) begin
      m_state[i] = M_IDLE; m_good[i] = 0; m_tref[i] = 0; m_pout[i] = 0; m_pv[i] = 0;
    end
  endtask

  task automatic model_step(input bit d, input bit c);
    bit r;
    int el;
    bit m;
    hist.push_front(d);
    r = hist[2] && !hist[3];
    void'(hist.pop_back());
    for (int i = 0; i < 2; i++) begin
      el = n_edge - m_tref[i];
      if (el > 65535) el = 65535;
      m = ((el > 4) ? el - 4 : 4 - el) <= tolv[i];
      m_pv[i] = 0;
      if (c) begin
        m_state[i] = M_IDLE; m_good[i] = 0; m_tref[i] = n_edge + 1;
      end else if (r) begin
        m_tref[i] = n_edge;
        if (m_state[i] != M_IDLE) begin
          m_pv[i] = 1; m_pout[i] = el;
        end
        if (m_state[i] == M_IDLE) m_state[i] = M_MEAS;
        else if (m_state[i] == M_MEAS) begin
          if (m) begin
            if (m_good[i] < 4) m_good[i]++;
            if (m_good[i] == 4) m_state[i] = M_LOCK;
          end else m_good[i] = 0;
        end else if (m_state[i] == M_LOCK && !m) m_state[i] = M_FLT;
      end else if (m_state[i] != M_FLT && el >= 16) begin
        m_state[i] = M_FLT;
      end
    end
    n_edge++;
  endtask

  task automatic compare_all();
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("u%0d.period_out", i),   pout[i], m_pout[i]);
      chk($sformatf("u%0d.period_valid", i), pv[i],   m_pv[i]);
      chk($sformatf("u%0d.locked", i),       lk[i],   m_state[i] == M_LOCK);
      chk($sformatf("u%0d.fault", i),        ft[i],   m_state[i] == M_FLT);
    end
  endtask

  // Entered and left at a falling edge.
  task automatic tick(input bit d, input bit c);
    div_in = d;
    clr    = c;
    @(posedge clk);
    model_step(d, c);
    #1;
    compare_all();
    @(negedge clk);
  endtask

  task automatic per(input int len);
    int hi;
    hi = (len / 2 < 1) ? 1 : len / 2;
    for (int i = 0; i < len; i++) tick(i < hi, 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b1; div_in = 1'b0; clr = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("rst u%0d.outputs", i), {pout[i], pv[i], lk[i], ft[i]}, 0);
    end
    rst = 1'b0;
    model_reset();
  endtask

  typedef struct {
    bit d;
    bit pv;
    int po;
    bit lk;
  } vec_t;

  vec_t tbl [20];

  initial begin
    tbl = '{'{1,0,0,0}, '{1,0,0,0}, '{0,0,0,0}, '{0,0,0,0},
            '{1,0,0,0}, '{1,0,0,0}, '{0,1,4,0}, '{0,0,4,0},
            '{1,0,4,0}, '{1,0,4,0}, '{0,1,4,0}, '{0,0,4,0},
            '{1,0,4,0}, '{1,0,4,0}, '{0,1,4,0}, '{0,0,4,0},
            '{1,0,4,0}, '{1,0,4,0}, '{0,1,4,1}, '{0,0,4,1}};

    rst = 1'b1; div_in = 1'b0; clr = 1'b0;
    @(negedge clk);
    do_reset();

    // Default lock sequence, hand-computed expectations.
    for (int k = 0; k < 20; k++) begin
      tick(tbl[k].d, 1'b0);
      chk($sformatf("tbl[%0d].period_valid", k), pv[0],   tbl[k].pv);
      chk($sformatf("tbl[%0d].period_out", k),   pout[0], tbl[k].po);
      chk($sformatf("tbl[%0d].locked", k),       lk[0],   tbl[k].lk);
      chk($sformatf("tbl[%0d].fault", k),        ft[0],   0);
    end

    // One long period while locked.
    per(4); per(4);
    chk("pre5.locked", lk[0], 1);
    per(5);
    tick(1'b1, 1'b0); tick(1'b1, 1'b0); tick(1'b0, 1'b0);
    chk("p5.period_valid", pv[0], 1);
    chk("p5.period_out", pout[0], 5);
    chk("p5.fault", ft[0], 1);
    chk("p5.locked", lk[0], 0);
    chk("p5.u1_locked", lk[1], 1);
    tick(1'b0, 1'b0);
    per(4); per(4); per(4);
    chk("sticky.fault", ft[0], 1);
    chk("sticky.period_out", pout[0], 4);

    // clr coincident with a rise in FAULT.
    tick(1'b1, 1'b0); tick(1'b1, 1'b0); tick(1'b0, 1'b1);
    chk("clr.period_valid", pv[0], 0);
    chk("clr.fault", ft[0], 0);
    chk("clr.locked", lk[0], 0);
    tick(1'b0, 1'b0);
    per(4); per(4); per(4); per(4);
    chk("relock.before", lk[0], 0);
    per(4);
    chk("relock.after", lk[0], 1);

    // div_in stuck low after lock.
    repeat (14) tick(1'b0, 1'b0);
    chk("stuck.fault_before", ft[0], 0);
    tick(1'b0, 1'b0);
    chk("stuck.fault_at16", ft[0], 1);
    chk("stuck.period_valid", pv[0], 0);
    repeat (3) tick(1'b0, 1'b0);

    // Asynchronous reset mid-period while locked.
    tick(1'b0, 1'b1);
    repeat (5) per(4);
    chk("arst.locked_before", lk[0], 1);
    tick(1'b1, 1'b0);
    #2 rst = 1'b1;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("arst u%0d.outputs", i), {pout[i], pv[i], lk[i], ft[i]}, 0);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    per(4);
    chk("arst.first_rise_pout", pout[0], 0);
    per(4);
    chk("arst.second_rise_pout", pout[0], 4);

    // Tolerance instance: 3,5,4,3 lock, then 6 faults.
    do_reset();
    per(3); per(5); per(4); per(3);
    chk("tol.locked_early", lk[1], 0);
    per(6);
    chk("tol.locked", lk[1], 1);
    per(4);
    chk("tol.fault", ft[1], 1);
    chk("tol.locked_after", lk[1], 0);
    chk("tol.period_out", pout[1], 6);

    // Randomized traffic against the model.
    do_reset();
    for (int it = 0; it < 150; it++) begin
      int hi_len;
      int lo_len;
      hi_len = $urandom_range(1, 3);
      lo_len = ($urandom_range(0, 19) == 0) ? 20 : $urandom_range(1, 4);
      for (int j = 0; j < hi_len + lo_len; j++) begin
        tick(j < hi_len, $urandom_range(0, 39) == 0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
